// File: rtl/pdm_cic_array.sv
// Multi-line PDM front end: PDM clock, dual-edge sampling,
// per-channel CIC decimation and a channel-tagged PCM FIFO.
module pdm_cic_array #(
  parameter int LINES          = 2,
  parameter int CIC_ORDER      = 3,
  parameter int MAX_DECIMATION = 128,
  parameter int PCM_WIDTH      = 16,
  parameter int FIFO_DEPTH     = 8,
  localparam int W  = CIC_ORDER*$clog2(MAX_DECIMATION)+1,
  localparam int SW = $clog2(W),
  localparam int CH = 2*LINES,
  localparam int CW = $clog2(CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [7:0]           clock_divisor_i,
  input  logic [7:0]           decimation_i,
  input  logic [SW-1:0]        shift_i,
  input  logic [LINES-1:0]     pdm_data_i,
  output logic                 pdm_clk_o,
  output logic [PCM_WIDTH-1:0] pcm_o,
  output logic [CW-1:0]        channel_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  input  logic                 clear_i
);

  localparam int N   = CIC_ORDER;
  localparam int DW  = $clog2(MAX_DECIMATION);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = $clog2(N+2);
  localparam int XW  = (W > PCM_WIDTH) ? W : PCM_WIDTH;
  localparam logic [8:0] MAXD = 9'(MAX_DECIMATION);
  localparam logic [WCW-1:0] WARM = WCW'(N+1);
  localparam logic signed [XW-1:0] PMAX =
    {{(XW-PCM_WIDTH+1){1'b0}}, {(PCM_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] PMIN =
    {{(XW-PCM_WIDTH+1){1'b1}}, {(PCM_WIDTH-1){1'b0}}};

  logic          en_q, run;
  logic [7:0]    div_q;
  logic [DW-1:0] dm1_q;
  logic [SW-1:0] shift_q;
  logic [8:0]    d_in, d_cl;

  // run is held off for the enable-rise cycle so config is latched first
  assign run  = enable_i & en_q;
  assign d_in = {1'b0, decimation_i};

  always_comb begin
    d_cl = d_in;
    if (d_in < 9'd2)      d_cl = 9'd2;
    else if (d_in > MAXD) d_cl = MAXD;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q    <= 1'b0;
      div_q   <= '0;
      dm1_q   <= '0;
      shift_q <= '0;
    end else begin
      en_q <= enable_i;
      if (enable_i && !en_q) begin
        div_q   <= clock_divisor_i;
        dm1_q   <= DW'(d_cl - 9'd1);
        shift_q <= shift_i;
      end
    end
  end

  logic [7:0]    div_cnt;
  logic [DW-1:0] dec_cnt;
  logic          pdm_clk_q, tick, rise, fall, snap_req;

  assign tick = run && (div_cnt == div_q);
  assign rise = tick & ~pdm_clk_q;
  assign fall = tick & pdm_clk_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt   <= '0;
      dec_cnt   <= '0;
      pdm_clk_q <= 1'b0;
      snap_req  <= 1'b0;
    end else if (!run) begin
      div_cnt   <= '0;
      dec_cnt   <= '0;
      pdm_clk_q <= 1'b0;
      snap_req  <= 1'b0;
    end else begin
      snap_req <= 1'b0;
      if (tick) begin
        div_cnt   <= '0;
        pdm_clk_q <= ~pdm_clk_q;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall) begin
        if (dec_cnt == dm1_q) begin
          dec_cnt  <= '0;
          snap_req <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt + DW'(1);
        end
      end
    end
  end

  logic [W-1:0] integ [CH][N];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < N; i++)
          integ[c][i] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (!run) begin
          for (int i = 0; i < N; i++)
            integ[c][i] <= '0;
        end else if ((c % 2 == 1) ? rise : fall) begin
          integ[c][0] <= integ[c][0] +
            (pdm_data_i[c/2] ? W'(1) : '1);
          for (int i = 1; i < N; i++)
            integ[c][i] <= integ[c][i] + integ[c][i-1];
        end
      end
    end
  end

  logic [W-1:0]   snap [CH];
  logic [WCW-1:0] warm;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH; c++) snap[c] <= '0;
      warm <= '0;
    end else if (!run) begin
      for (int c = 0; c < CH; c++) snap[c] <= '0;
      warm <= '0;
    end else if (snap_req) begin
      for (int c = 0; c < CH; c++) snap[c] <= integ[c][N-1];
      if (warm != WARM) warm <= warm + WCW'(1);
    end
  end

  typedef enum logic {IDLE, RUN} seq_t;
  seq_t          st, st_n;
  logic [CW-1:0] idx, idx_n;
  logic          push;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st  <= IDLE;
      idx <= '0;
    end else if (!run) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
    end
  end

  always_comb begin
    st_n  = st;
    idx_n = idx;
    push  = 1'b0;
    unique case (st)
      IDLE: begin
        if (snap_req) begin
          st_n  = RUN;
          idx_n = '0;
        end
      end
      RUN: begin
        push = (warm == WARM);
        if (idx == CW'(CH-1)) st_n = IDLE;
        else idx_n = idx + CW'(1);
      end
    endcase
  end

  logic [W-1:0] comb_d [CH][N];
  logic [W-1:0] cin [N];
  logic [W-1:0] cout;

  always_comb begin
    cout = snap[idx];
    for (int i = 0; i < N; i++) begin
      cin[i] = cout;
      cout   = cout - comb_d[idx][i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < N; i++)
          comb_d[c][i] <= '0;
    end else if (!run) begin
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < N; i++)
          comb_d[c][i] <= '0;
    end else if (st == RUN) begin
      for (int i = 0; i < N; i++)
        comb_d[idx][i] <= cin[i];
    end
  end

  logic signed [W-1:0]  shd;
  logic signed [XW-1:0] shx;
  logic [PCM_WIDTH-1:0] pcm_s;

  assign shd = $signed(cout) >>> shift_q;
  assign shx = XW'(shd);

  always_comb begin
    pcm_s = shx[PCM_WIDTH-1:0];
    if (shx > PMAX)      pcm_s = PMAX[PCM_WIDTH-1:0];
    else if (shx < PMIN) pcm_s = PMIN[PCM_WIDTH-1:0];
  end

  logic [CW+PCM_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW+PCM_WIDTH-1:0] head;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full, pop, wr_en, drop, ovr_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & ready_i;
  // a pop in the same cycle frees the slot, so the push still lands
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {idx, pcm_s};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!run) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ovr_q <= 1'b0;
    else          ovr_q <= (ovr_q & ~clear_i) | drop;
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign valid_o   = ~empty;
  assign pcm_o     = empty ? '0 : head[PCM_WIDTH-1:0];
  assign channel_o = empty ? '0 : head[CW+PCM_WIDTH-1:PCM_WIDTH];
  assign pdm_clk_o = pdm_clk_q;
  assign overrun_o = ovr_q;

endmodule
